tcm_capture_ctrl: RTL and testbench

Controller that sequences the 32-word TCM capture buffer.
- Arms a capture and drives S_AXIS_TREADY, so the stream is only accepted while a capture is running.
- Generates the BRAM write enable and write address for each accepted word, and ends the frame on length or TLAST.
- Once a capture is complete, round-robin arbitrates the single BRAM read port between two readback requesters.
- TDATA goes straight to the BRAM; this block only produces control and address signals.

---
 rtl/tcm_pkg.sv | 22 ++
 rtl/tcm_capture_ctrl_rd_arb.sv | 46 ++++
 rtl/tcm_capture_ctrl.sv | 118 +++++++++++
 tb/tb_tcm_capture_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_pkg.sv
// Shared constants and state encoding for the TCM capture controller.
package tcm_pkg;

    localparam int unsigned TCM_DEPTH = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned LEN_W     = 6;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } tcm_state_t;

    // Zero or out-of-range lengths select a full-buffer frame.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        if (len == '0 || len > LEN_W'(TCM_DEPTH))
            return LEN_W'(TCM_DEPTH);
        return len;
    endfunction

endpackage

// File: rtl/tcm_capture_ctrl_rd_arb.sv
// Two-way round-robin arbiter for the single BRAM read port, with address mux
// and one-cycle read-valid pipeline.
module tcm_rd_arb
    import tcm_pkg::*;
#(
    parameter int unsigned ADDR_W = tcm_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [1:0]        grant,
    output logic [1:0]        valid,
    output logic [ADDR_W-1:0] rd_addr
);

    logic last_served;

    always_comb begin
        grant = '0;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_served ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    assign rd_addr = grant[1] ? addr1 : addr0;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_served <= 1'b1;
            valid       <= '0;
        end else begin
            valid <= grant;
            if (grant != '0)
                last_served <= grant[1];
        end
    end

endmodule

// File: rtl/tcm_capture_ctrl.sv
// Capture sequencer for the 32-word TCM buffer: stream handshake, BRAM write
// addressing, frame termination and post-capture readback arbitration.
module tcm_capture_ctrl
    import tcm_pkg::*;
(
    input  logic              S_AXIS_ACLK,
    input  logic              S_AXIS_ARESET,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              S_AXIS_TVALID,
    input  logic              S_AXIS_TLAST,
    output logic              S_AXIS_TREADY,
    output logic              tcm_wr_en,
    output logic [ADDR_W-1:0] tcm_wr_addr,
    output logic [ADDR_W-1:0] tcm_rd_addr,
    input  logic [1:0]        rd_req,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [1:0]        rd_grant,
    output logic [1:0]        rd_valid,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              short_frame,
    output logic [LEN_W-1:0]  word_count
);

    tcm_state_t        state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  len_q;
    logic              ovf_q, short_q;
    logic              hs, start_acc, last_word, rd_en;

    assign busy          = (state == S_CAPTURE) || (state == S_DRAIN);
    assign done          = (state == S_DONE);
    assign rd_en         = (state == S_IDLE) || (state == S_DONE);
    assign S_AXIS_TREADY = busy;
    assign hs            = S_AXIS_TVALID & S_AXIS_TREADY;
    assign tcm_wr_en     = hs & (state == S_CAPTURE);
    assign start_acc     = cfg_start & ~cfg_abort & rd_en;
    assign last_word     = ({1'b0, count} + 1'b1) == {1'b0, len_q};

    assign tcm_wr_addr = wr_ptr;
    assign word_count  = count;
    assign overflow    = ovf_q;
    assign short_frame = short_q;

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cfg_abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (cfg_start) state_nxt = S_CAPTURE;
                S_CAPTURE: begin
                    if (hs) begin
                        if (last_word)
                            state_nxt = S_AXIS_TLAST ? S_DONE : S_DRAIN;
                        else if (S_AXIS_TLAST)
                            state_nxt = S_DONE;
                    end
                end
                S_DRAIN:   if (hs && S_AXIS_TLAST) state_nxt = S_DONE;
                S_DONE:    if (cfg_start) state_nxt = S_CAPTURE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // A write coinciding with cfg_abort still lands and is counted.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            wr_ptr  <= '0;
            count   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
        end else if (start_acc) begin
            wr_ptr  <= '0;
            count   <= '0;
            len_q   <= eff_len(cfg_len);
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
        end else if (tcm_wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != LEN_W'(TCM_DEPTH))
                count <= count + 1'b1;
            if (last_word && !S_AXIS_TLAST)
                ovf_q <= 1'b1;
            if (!last_word && S_AXIS_TLAST)
                short_q <= 1'b1;
        end
    end

    tcm_rd_arb #(
        .ADDR_W(ADDR_W)
    ) u_rd_arb (
        .clk     (S_AXIS_ACLK),
        .rst     (S_AXIS_ARESET),
        .en      (rd_en),
        .req     (rd_req),
        .addr0   (rd_addr0),
        .addr1   (rd_addr1),
        .grant   (rd_grant),
        .valid   (rd_valid),
        .rd_addr (tcm_rd_addr)
    );

endmodule

// File: tb/tb_tcm_capture_ctrl.sv
// Scoreboard bench for tcm_capture_ctrl: frame-level reference model feeds
// expectation queues that a negedge monitor drains as the DUT produces outputs.
module tb_tcm_capture_ctrl;
    import tcm_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start, cfg_abort;
    logic [LEN_W-1:0]  cfg_len;
    logic              tvalid, tlast, tready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [1:0]        rd_req, rd_grant, rd_valid;
    logic [ADDR_W-1:0] rd_addr0, rd_addr1;
    logic              busy, done, overflow, short_frame;
    logic [LEN_W-1:0]  word_count;

    always #5 clk = ~clk;

    tcm_capture_ctrl dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_len       (cfg_len),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .tcm_wr_en     (wr_en),
        .tcm_wr_addr   (wr_addr),
        .tcm_rd_addr   (rd_addr),
        .rd_req        (rd_req),
        .rd_addr0      (rd_addr0),
        .rd_addr1      (rd_addr1),
        .rd_grant      (rd_grant),
        .rd_valid      (rd_valid),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .short_frame   (short_frame),
        .word_count    (word_count)
    );

    typedef struct packed {
        logic [1:0]        gnt;
        logic [ADDR_W-1:0] addr;
    } gnt_t;

    typedef struct {
        int wc;
        int ovf;
        int shrt;
    } st_t;

    int   vectors     = 0;
    int   miscompares = 0;
    int   wr_q[$];
    gnt_t gnt_q[$];
    logic [1:0] val_q[$];
    st_t  st_q[$];
    int   last_served = 1;
    logic done_d      = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void unexpected(input string name, input int act);
        vectors++;
        miscompares++;
        $display("FAIL %s: DUT output %0d with nothing expected (t=%0t)", name, act, $time);
    endfunction

    // Round-robin reference: whoever was served last loses a tie.
    function automatic void arb_expect(input logic [1:0] req,
                                       input logic [ADDR_W-1:0] a0,
                                       input logic [ADDR_W-1:0] a1);
        int   idx;
        gnt_t e;
        if (req == 2'b00) return;
        if (req == 2'b11) idx = (last_served == 1) ? 0 : 1;
        else              idx = (req == 2'b01) ? 0 : 1;
        last_served = idx;
        e.gnt  = (idx == 1) ? 2'b10 : 2'b01;
        e.addr = (idx == 1) ? a1 : a0;
        gnt_q.push_back(e);
        val_q.push_back(e.gnt);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (wr_q.size() == 0) unexpected("wr_en", int'(wr_addr));
                else chk("wr_addr", int'(wr_addr), wr_q.pop_front());
            end
            if (rd_grant != 2'b00) begin
                if (gnt_q.size() == 0) unexpected("rd_grant", int'(rd_grant));
                else begin
                    gnt_t e;
                    e = gnt_q.pop_front();
                    chk("rd_grant", int'(rd_grant), int'(e.gnt));
                    chk("tcm_rd_addr", int'(rd_addr), int'(e.addr));
                end
            end
            if (rd_valid != 2'b00) begin
                if (val_q.size() == 0) unexpected("rd_valid", int'(rd_valid));
                else chk("rd_valid", int'(rd_valid), int'(val_q.pop_front()));
            end
            if (done && !done_d) begin
                if (st_q.size() == 0) unexpected("done", 1);
                else begin
                    st_t s;
                    s = st_q.pop_front();
                    chk("word_count", int'(word_count), s.wc);
                    chk("overflow", int'(overflow), s.ovf);
                    chk("short_frame", int'(short_frame), s.shrt);
                end
            end
        end
        done_d = done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arb_cycle(input logic [1:0] req);
        rd_req   = req;
        rd_addr0 = ADDR_W'($urandom);
        rd_addr1 = ADDR_W'($urandom);
        arb_expect(rd_req, rd_addr0, rd_addr1);
        step();
        rd_req = 2'b00;
    endtask

    // Arm a frame (a grant may coincide with the start) and stream n beats,
    // TLAST on the final one.
    task automatic send_frame(input int len, input int n, input bit gaps);
        int   eff, beats, cyc;
        st_t  s;
        eff    = (len == 0 || len > 32) ? 32 : len;
        s.wc   = (n < eff) ? n : eff;
        s.ovf  = (n > eff) ? 1 : 0;
        s.shrt = (n < eff) ? 1 : 0;
        st_q.push_back(s);
        cfg_len   = LEN_W'(len);
        cfg_start = 1'b1;
        rd_req    = 2'($urandom);
        rd_addr0  = ADDR_W'($urandom);
        rd_addr1  = ADDR_W'($urandom);
        arb_expect(rd_req, rd_addr0, rd_addr1);
        step();
        beats = 0;
        cyc   = 0;
        while (beats < n && cyc < 400) begin
            tvalid    = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            tlast     = (beats == n - 1);
            cfg_start = ($urandom_range(0, 7) == 0);
            rd_req    = 2'($urandom);
            rd_addr0  = ADDR_W'($urandom);
            rd_addr1  = ADDR_W'($urandom);
            if (tvalid && tready) begin
                if (beats < eff) wr_q.push_back(beats);
                beats++;
            end
            step();
            cyc++;
        end
        tvalid    = 1'b0;
        tlast     = 1'b0;
        cfg_start = 1'b0;
        rd_req    = 2'b00;
        if (cyc >= 400) chk("frame_timeout", beats, n);
        chk("tready_after_last", int'(tready), 0);
        chk("done_after_last", int'(done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_len = '0;
        tvalid = 1'b0; tlast = 1'b0; rd_req = 2'b00; rd_addr0 = '0; rd_addr1 = '0;
        step(); step();
        chk("reset_outputs", int'({tready, wr_en, wr_addr, rd_addr, rd_grant, rd_valid,
                                   busy, done, overflow, short_frame, word_count}), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) arb_cycle(2'b11);
        for (int i = 0; i < 20; i++) arb_cycle(2'($urandom));

        send_frame(8, 8, 1'b0);
        for (int i = 0; i < 4; i++) arb_cycle(2'b11);
        send_frame(8, 3, 1'b0);
        send_frame(4, 7, 1'b0);
        send_frame(0, 32, 1'b0);
        send_frame(40, 33, 1'b1);
        send_frame(1, 1, 1'b1);
        for (int f = 0; f < 8; f++) begin
            send_frame($urandom_range(0, 40), $urandom_range(1, 40), 1'b1);
            for (int i = 0; i < 6; i++) arb_cycle(2'($urandom));
        end

        // Abort after two beats, with a simultaneous start that must lose.
        cfg_len = 6'd8; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tvalid = 1'b1;
            if (tready) wr_q.push_back(i);
            step();
        end
        tvalid = 1'b0; cfg_abort = 1'b1; cfg_start = 1'b1;
        step();
        cfg_abort = 1'b0; cfg_start = 1'b0;
        chk("abort_tready", int'(tready), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_word_count", int'(word_count), 2);
        step();
        chk("abort_start_ignored", int'(busy), 0);

        // Synchronous reset in the middle of a frame.
        cfg_len = 6'd10; cfg_start = 1'b1; rd_addr0 = '0; rd_addr1 = '0;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tvalid = 1'b1;
            if (tready) wr_q.push_back(i);
            step();
        end
        tvalid = 1'b0; rst = 1'b1;
        step();
        chk("midframe_reset_outputs", int'({tready, wr_en, wr_addr, rd_addr, rd_grant, rd_valid,
                                            busy, done, overflow, short_frame, word_count}), 0);
        rst = 1'b0;
        last_served = 1;
        step();
        for (int i = 0; i < 4; i++) arb_cycle(2'b11);
        send_frame(5, 5, 1'b1);
        for (int i = 0; i < 4; i++) step();

        chk("pending_writes", wr_q.size(), 0);
        chk("pending_grants", gnt_q.size(), 0);
        chk("pending_valids", val_q.size(), 0);
        chk("pending_status", st_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
